lcd_timing_gen: RTL and testbench

- Parametrised LCD/VGA raster timing generator. Successor to the fixed 800x480, divide-by-4 timing front end of the spectrogram display.
- Generates pixel clock, HSYNC/VSYNC/DE, pixel coordinates and a look-ahead coordinate for pixel pipelines of arbitrary latency.
- Supports a frame-synchronous enable, so the display pipeline can be stopped or restarted without producing torn frames.
- Sits between the system clock domain and the LCD pins. Downstream pixel generators consume the phase strobes and coordinates.

---
 rtl/lcd_timing_gen.sv | 143 ++++++++++++++
 tb/tb_lcd_timing_gen.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// Parametrised LCD/VGA raster timing generator with frame-synchronous
// enable, one-hot pixel phase and look-ahead coordinates.
module lcd_timing_gen #(
  parameter int   CDIV   = 4,
  parameter int   HW     = 11,
  parameter int   VW     = 10,
  parameter int   H_SYNC = 1,
  parameter int   H_BP   = 45,
  parameter int   H_ACT  = 800,
  parameter int   H_FP   = 210,
  parameter int   V_SYNC = 5,
  parameter int   V_BP   = 18,
  parameter int   V_ACT  = 480,
  parameter int   V_FP   = 22,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0,
  parameter int   LEAD   = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  output logic [CDIV-1:0] PHASE,
  output logic            PCLK,
  output logic            HSYNC,
  output logic            VSYNC,
  output logic            DE,
  output logic [HW-1:0]   H_POS,
  output logic [VW-1:0]   V_POS,
  output logic            LDE,
  output logic [HW-1:0]   LH_POS,
  output logic [VW-1:0]   LV_POS,
  output logic            LINE_START,
  output logic            FRAME_START,
  output logic            RUNNING
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_S    = HW'(H_SYNC);
  localparam logic [HW-1:0] H_A0   = HW'(H_SYNC + H_BP);
  localparam logic [HW-1:0] H_A1   = HW'(H_SYNC + H_BP + H_ACT);
  localparam logic [HW:0]   H_TOTX = (HW+1)'(H_TOT);
  localparam logic [HW:0]   LEAD_X = (HW+1)'(LEAD);

  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_S    = VW'(V_SYNC);
  localparam logic [VW-1:0] V_A0   = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_A1   = VW'(V_SYNC + V_BP + V_ACT);

  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic [CDIV-1:0] phase_nx;
  logic            tick;
  logic            h_wrap;
  logic            v_wrap;
  logic            go;
  logic [HW-1:0]   h_nx;
  logic [VW-1:0]   v_nx;
  logic [HW:0]     l_sum;
  logic [HW-1:0]   lh;
  logic [VW-1:0]   lv;
  logic            de_nx;
  logic            lde_nx;

  function automatic logic in_h(input logic [HW-1:0] x);
    return (x >= H_A0) && (x < H_A1);
  endfunction

  function automatic logic in_v(input logic [VW-1:0] y);
    return (y >= V_A0) && (y < V_A1);
  endfunction

  assign tick     = PHASE[CDIV-1];
  assign phase_nx = {PHASE[CDIV-2:0], PHASE[CDIV-1]};

  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    // Stopping is only allowed on the wrap back to the first pixel.
    go     = RUNNING ? !(h_wrap && v_wrap && !EN) : EN;
    h_nx   = '0;
    v_nx   = '0;
    if (RUNNING && go) begin
      h_nx = h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap)
        v_nx = v_wrap ? '0 : v_cnt + 1'b1;
      else
        v_nx = v_cnt;
    end
    l_sum = {1'b0, h_nx} + LEAD_X;
    lh    = l_sum[HW-1:0];
    lv    = v_nx;
    if (l_sum >= H_TOTX) begin
      lh = HW'(l_sum - H_TOTX);
      lv = (v_nx == V_LAST) ? '0 : v_nx + 1'b1;
    end
    de_nx  = go && in_h(h_nx) && in_v(v_nx);
    lde_nx = go && in_h(lh) && in_v(lv);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      PHASE       <= CDIV'(1);
      PCLK        <= 1'b0;
      RUNNING     <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      HSYNC       <= !HS_POL;
      VSYNC       <= !VS_POL;
      DE          <= 1'b0;
      H_POS       <= '0;
      V_POS       <= '0;
      LDE         <= 1'b0;
      LH_POS      <= '0;
      LV_POS      <= '0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      PHASE       <= phase_nx;
      PCLK        <= |phase_nx[CDIV-1:CDIV/2];
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
      if (tick) begin
        RUNNING     <= go;
        h_cnt       <= h_nx;
        v_cnt       <= v_nx;
        HSYNC       <= (go && h_nx < H_S) ? HS_POL : !HS_POL;
        VSYNC       <= (go && v_nx < V_S) ? VS_POL : !VS_POL;
        DE          <= de_nx;
        H_POS       <= de_nx ? h_nx - H_A0 : '0;
        V_POS       <= de_nx ? v_nx - V_A0 : '0;
        LDE         <= lde_nx;
        LH_POS      <= lde_nx ? lh - H_A0 : '0;
        LV_POS      <= lde_nx ? lv - V_A0 : '0;
        LINE_START  <= go && (h_nx == '0);
        FRAME_START <= go && (h_nx == '0) && (v_nx == '0);
      end
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: reference-model scoreboard on every CLK plus
// per-scenario period, region and control checks on a reduced raster.
module tb_lcd_timing_gen;

  localparam int CDIV = 4;
  localparam int HSY  = 2;
  localparam int HBP  = 4;
  localparam int HAC  = 16;
  localparam int HFP  = 2;
  localparam int VSY  = 1;
  localparam int VBP  = 1;
  localparam int VAC  = 4;
  localparam int VFP  = 1;
  localparam int LEAD = 2;
  localparam logic HSP = 1'b1;
  localparam logic VSP = 1'b0;
  localparam int HT    = HSY + HBP + HAC + HFP;
  localparam int VT    = VSY + VBP + VAC + VFP;
  localparam int HA0   = HSY + HBP;
  localparam int VA0   = VSY + VBP;
  localparam int FRAME = HT * VT * CDIV;

  typedef struct packed {
    logic [3:0]  ph;
    logic        pclk, hs, vs, de;
    logic [10:0] hp;
    logic [9:0]  vp;
    logic        lde;
    logic [10:0] lhp;
    logic [9:0]  lvp;
    logic        ls, fs, run;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic [3:0]  phase;
  logic        pclk, hs, vs, de, lde, ls, fs, run;
  logic [10:0] hp, lhp;
  logic [9:0]  vp, lvp;
  out_t obs;

  int checks = 0;
  int fails  = 0;
  out_t sb[$];

  lcd_timing_gen #(
    .CDIV(CDIV), .HW(11), .VW(10),
    .H_SYNC(HSY), .H_BP(HBP), .H_ACT(HAC), .H_FP(HFP),
    .V_SYNC(VSY), .V_BP(VBP), .V_ACT(VAC), .V_FP(VFP),
    .HS_POL(HSP), .VS_POL(VSP), .LEAD(LEAD)
  ) dut (
    .CLK(clk), .RST(rst), .EN(en),
    .PHASE(phase), .PCLK(pclk), .HSYNC(hs), .VSYNC(vs), .DE(de),
    .H_POS(hp), .V_POS(vp), .LDE(lde), .LH_POS(lhp), .LV_POS(lvp),
    .LINE_START(ls), .FRAME_START(fs), .RUNNING(run)
  );

  always #5 clk = ~clk;

  assign obs = {phase, pclk, hs, vs, de, hp, vp, lde, lhp, lvp,
                ls, fs, run};

  // reference model: pixel-level behaviour, one expectation per CLK
  initial begin
    int m_ph, m_x, m_y, lx, ly;
    bit m_run, m_ls, m_fs, tk, e_de, e_lde;
    out_t e;
    m_ph = 0; m_x = 0; m_y = 0;
    m_run = 0; m_ls = 0; m_fs = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_ph = 0; m_run = 0; m_x = 0; m_y = 0; m_ls = 0; m_fs = 0;
      end else begin
        tk   = (m_ph == CDIV - 1);
        m_ph = (m_ph + 1) % CDIV;
        m_ls = 0;
        m_fs = 0;
        if (tk) begin
          if (m_run) begin
            m_x++;
            if (m_x == HT) begin
              m_x = 0;
              m_y = (m_y + 1) % VT;
            end
            if (m_x == 0 && m_y == 0 && !en) m_run = 0;
          end else if (en) begin
            m_run = 1; m_x = 0; m_y = 0;
          end
          m_ls = m_run && m_x == 0;
          m_fs = m_ls && m_y == 0;
        end
      end
      lx = m_x + LEAD;
      ly = m_y;
      if (lx >= HT) begin
        lx -= HT;
        ly = (ly + 1) % VT;
      end
      e_de  = m_run && m_x >= HA0 && m_x < HA0 + HAC &&
              m_y >= VA0 && m_y < VA0 + VAC;
      e_lde = m_run && lx >= HA0 && lx < HA0 + HAC &&
              ly >= VA0 && ly < VA0 + VAC;
      e.ph   = 4'(1 << m_ph);
      e.pclk = (m_ph >= CDIV / 2);
      e.hs   = (m_run && m_x < HSY) ? HSP : !HSP;
      e.vs   = (m_run && m_y < VSY) ? VSP : !VSP;
      e.de   = e_de;
      e.hp   = e_de ? 11'(m_x - HA0) : 11'd0;
      e.vp   = e_de ? 10'(m_y - VA0) : 10'd0;
      e.lde  = e_lde;
      e.lhp  = e_lde ? 11'(lx - HA0) : 11'd0;
      e.lvp  = e_lde ? 10'(ly - VA0) : 10'd0;
      e.ls   = m_ls;
      e.fs   = m_fs;
      e.run  = m_run;
      sb.push_back(e);
    end
  end

  initial begin
    out_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if (obs !== x) begin
          fails++;
          $display("FAIL scoreboard t=%0t got=%h exp=%h", $time, obs, x);
        end
      end
    end
  end

  task automatic test_reset();
    logic [3:0] eph [4];
    logic       epc [4];
    eph = '{4'd2, 4'd4, 4'd8, 4'd1};
    epc = '{1'b0, 1'b1, 1'b1, 1'b0};
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (phase !== 4'd1 || pclk !== 1'b0 || run !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl got ph=%h pclk=%b run=%b exp 1 0 0",
               phase, pclk, run);
    end
    checks++;
    if (hs !== !HSP || vs !== !VSP || de !== 1'b0 || lde !== 1'b0) begin
      fails++;
      $display("FAIL reset_sync got hs=%b vs=%b de=%b lde=%b exp %b %b 0 0",
               hs, vs, de, lde, !HSP, !VSP);
    end
    checks++;
    if (hp !== 0 || vp !== 0 || ls !== 0 || fs !== 0) begin
      fails++;
      $display("FAIL reset_pos got hp=%0d vp=%0d ls=%b fs=%b exp 0",
               hp, vp, ls, fs);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (phase !== eph[i] || pclk !== epc[i]) begin
        fails++;
        $display("FAIL phase_seq[%0d] got ph=%h pclk=%b exp ph=%h pclk=%b",
                 i, phase, pclk, eph[i], epc[i]);
      end
    end
    repeat (8) @(negedge clk);
    checks++;
    if (run !== 1'b0) begin
      fails++;
      $display("FAIL idle_en0 got run=%b exp 0", run);
    end
  endtask

  task automatic test_frame();
    int n, last_ls, lde_rise, lde_fall, de_lines, de_cyc, hs_cyc;
    int hp_max, vp_max, fs_seen;
    bit pde, plde;
    en = 1'b1;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs && n < 2 * FRAME);
    checks++;
    if (!fs) begin
      fails++;
      $display("FAIL frame_start_timeout got none exp within %0d", 2 * FRAME);
      return;
    end
    last_ls = 0; lde_rise = -1000; lde_fall = -1000;
    de_lines = 0; de_cyc = 0; hs_cyc = 0;
    hp_max = 0; vp_max = 0; fs_seen = 0;
    pde = de; plde = lde;
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      if (ls) begin
        checks++;
        if (c - last_ls != HT * CDIV) begin
          fails++;
          $display("FAIL line_period got %0d exp %0d", c - last_ls, HT * CDIV);
        end
        last_ls = c;
      end
      if (lde && !plde) begin
        lde_rise = c;
        checks++;
        if (lhp !== 11'd0) begin
          fails++;
          $display("FAIL lde_rise_lhpos got %0d exp 0", lhp);
        end
      end
      if (!lde && plde) lde_fall = c;
      if (de && !pde) begin
        de_lines++;
        checks++;
        if (c - last_ls != HA0 * CDIV || c - lde_rise != LEAD * CDIV) begin
          fails++;
          $display("FAIL de_rise got ls_dly=%0d lead=%0d exp %0d %0d",
                   c - last_ls, c - lde_rise, HA0 * CDIV, LEAD * CDIV);
        end
      end
      if (!de && pde) begin
        checks++;
        if (c - lde_fall != LEAD * CDIV) begin
          fails++;
          $display("FAIL lde_fall_lead got %0d exp %0d",
                   c - lde_fall, LEAD * CDIV);
        end
      end
      if (fs) begin
        fs_seen++;
        checks++;
        if (c != FRAME) begin
          fails++;
          $display("FAIL frame_period got %0d exp %0d", c, FRAME);
        end
      end
      if (de) begin
        de_cyc++;
        if (int'(hp) > hp_max) hp_max = int'(hp);
        if (int'(vp) > vp_max) vp_max = int'(vp);
      end
      if (hs === HSP) hs_cyc++;
      pde = de;
      plde = lde;
    end
    checks++;
    if (de_lines != VAC || de_cyc != VAC * HAC * CDIV) begin
      fails++;
      $display("FAIL de_count got lines=%0d cyc=%0d exp %0d %0d",
               de_lines, de_cyc, VAC, VAC * HAC * CDIV);
    end
    checks++;
    if (hs_cyc != VT * HSY * CDIV || fs_seen != 1) begin
      fails++;
      $display("FAIL hsync_count got hs=%0d fs=%0d exp %0d 1",
               hs_cyc, fs_seen, VT * HSY * CDIV);
    end
    checks++;
    if (hp_max != HAC - 1 || vp_max != VAC - 1) begin
      fails++;
      $display("FAIL pos_range got hmax=%0d vmax=%0d exp %0d %0d",
               hp_max, vp_max, HAC - 1, VAC - 1);
    end
  endtask

  task automatic test_en_drop();
    int n, lines, frames;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(de && vp == 10'd2) && n < 2 * FRAME);
    checks++;
    if (!(de && vp == 10'd2)) begin
      fails++;
      $display("FAIL drop_wait got none exp de at vp=2");
      return;
    end
    en = 1'b0;
    n = 0; lines = 0; frames = 0;
    do begin
      @(negedge clk);
      n++;
      if (ls) lines++;
      if (fs) frames++;
    end while (run && n < 2 * FRAME);
    checks++;
    if (run !== 1'b0 || lines != VT - 1 - (VA0 + 2) || frames != 0) begin
      fails++;
      $display("FAIL frame_complete got run=%b lines=%0d fs=%0d exp 0 %0d 0",
               run, lines, frames, VT - 1 - (VA0 + 2));
    end
    frames = 0;
    repeat (HT * CDIV) begin
      @(negedge clk);
      if (fs || run || de) frames++;
    end
    checks++;
    if (frames != 0) begin
      fails++;
      $display("FAIL stopped_idle got %0d active cycles exp 0", frames);
    end
    en = 1'b1;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs && n < 2 * CDIV);
    checks++;
    if (!fs || n > CDIV || run !== 1'b1) begin
      fails++;
      $display("FAIL restart got fs=%b after %0d run=%b exp 1 <=%0d 1",
               fs, n, run, CDIV);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(de && hp == 11'd10 && vp == 10'd1) && n < 2 * FRAME);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (run !== 0 || phase !== 4'd1 || pclk !== 0 || hs !== !HSP ||
        vs !== !VSP || de !== 0 || lde !== 0 || hp !== 0 ||
        lhp !== 0 || ls !== 0 || fs !== 0) begin
      fails++;
      $display("FAIL mid_reset got %h exp idle outputs", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs && n < 4 * CDIV);
    checks++;
    if (!fs || n != CDIV) begin
      fails++;
      $display("FAIL first_tick_fs got fs=%b after %0d exp 1 after %0d",
               fs, n, CDIV);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs && n < 2 * FRAME);
    checks++;
    if (!fs || n != FRAME) begin
      fails++;
      $display("FAIL back_to_back got fs=%b after %0d exp 1 after %0d",
               fs, n, FRAME);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame();
    test_en_drop();
    test_mid_reset();
    test_back_to_back();
    @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
